// File: rtl/sfr_access_ctrl.sv
// SFR bus initiator: turns CPU byte/bit accesses into read, write and
// read-modify-write cycles on the internal SFR bus.
module sfr_access_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        bitsel,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] sfrdatai,
   output logic [ADDR_W-1:0] sfraddr,
   output logic [DATA_W-1:0] sfrdatao,
   output logic              sfrwe,
   output logic              rmwinstr,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              bitval,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      OP_READ  = 3'd0,
      OP_WRITE = 3'd1,
      OP_SETB  = 3'd2,
      OP_CLRB  = 3'd3,
      OP_CPLB  = 3'd4,
      OP_ANL   = 3'd5,
      OP_ORL   = 3'd6,
      OP_XRL   = 3'd7
   } op_t;

   state_t              r_state,    w_state;
   op_t                 r_op,       w_op;
   logic [ADDR_W-1:0]   r_addr,     w_addr;
   logic [2:0]          r_bitsel,   w_bitsel;
   logic [DATA_W-1:0]   r_wdata,    w_wdata;
   logic [ADDR_W-1:0]   r_sfraddr,  w_sfraddr;
   logic [DATA_W-1:0]   r_sfrdatao, w_sfrdatao;
   logic                r_sfrwe,    w_sfrwe;
   logic                r_rmw,      w_rmw;
   logic                r_busy,     w_busy;
   logic                r_done,     w_done;
   logic [DATA_W-1:0]   r_rdata,    w_rdata;
   logic                r_bitval,   w_bitval;
   logic                r_err,      w_err;

   op_t                 w_req_op;
   logic                w_req_isbit;
   logic                w_cur_isbit;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   w_modified;

   assign w_req_op    = op_t'(op);
   assign w_req_isbit = (w_req_op == OP_SETB) || (w_req_op == OP_CLRB) || (w_req_op == OP_CPLB);
   assign w_cur_isbit = (r_op == OP_SETB) || (r_op == OP_CLRB) || (r_op == OP_CPLB);

   // Modify stage works on the live read data so the write can follow RD directly
   always_comb begin
      w_mask = DATA_W'(1) << r_bitsel;
      case (r_op)
         OP_SETB: w_modified = sfrdatai | w_mask;
         OP_CLRB: w_modified = sfrdatai & ~w_mask;
         OP_CPLB: w_modified = sfrdatai ^ w_mask;
         OP_ANL:  w_modified = sfrdatai & r_wdata;
         OP_ORL:  w_modified = sfrdatai | r_wdata;
         OP_XRL:  w_modified = sfrdatai ^ r_wdata;
         default: w_modified = r_wdata;
      endcase
   end

   always_comb begin
      w_state    = r_state;
      w_op       = r_op;
      w_addr     = r_addr;
      w_bitsel   = r_bitsel;
      w_wdata    = r_wdata;
      w_sfraddr  = '0;
      w_sfrdatao = r_sfrdatao;
      w_sfrwe    = 1'b0;
      w_rmw      = 1'b0;
      w_done     = 1'b0;
      w_rdata    = r_rdata;
      w_bitval   = r_bitval;
      w_err      = r_err;

      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_op     = w_req_op;
               w_addr   = addr;
               w_bitsel = bitsel;
               w_wdata  = wdata;
               w_err    = 1'b0;
               w_bitval = 1'b0;
               if (w_req_isbit && (addr[2:0] != 3'd0)) begin
                  w_state = S_DONE;
                  w_err   = 1'b1;
                  w_done  = 1'b1;
               end else if (w_req_op == OP_WRITE) begin
                  w_state    = S_WR;
                  w_sfraddr  = addr;
                  w_sfrdatao = wdata;
                  w_sfrwe    = 1'b1;
               end else begin
                  w_state   = S_RD;
                  w_sfraddr = addr;
                  w_rmw     = (w_req_op != OP_READ);
               end
            end
         end
         S_RD: begin
            w_rdata = sfrdatai;
            if (w_cur_isbit) begin
               w_bitval = sfrdatai[r_bitsel];
            end
            if (r_op == OP_READ) begin
               w_state = S_DONE;
               w_done  = 1'b1;
            end else begin
               w_state    = S_WR;
               w_sfraddr  = r_addr;
               w_sfrdatao = w_modified;
               w_sfrwe    = 1'b1;
               w_rmw      = 1'b1;
            end
         end
         S_WR: begin
            w_state = S_DONE;
            w_done  = 1'b1;
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_op       <= OP_READ;
         r_addr     <= '0;
         r_bitsel   <= '0;
         r_wdata    <= '0;
         r_sfraddr  <= '0;
         r_sfrdatao <= '0;
         r_sfrwe    <= 1'b0;
         r_rmw      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rdata    <= '0;
         r_bitval   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_op       <= w_op;
         r_addr     <= w_addr;
         r_bitsel   <= w_bitsel;
         r_wdata    <= w_wdata;
         r_sfraddr  <= w_sfraddr;
         r_sfrdatao <= w_sfrdatao;
         r_sfrwe    <= w_sfrwe;
         r_rmw      <= w_rmw;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_rdata    <= w_rdata;
         r_bitval   <= w_bitval;
         r_err      <= w_err;
      end
   end

   assign sfraddr  = r_sfraddr;
   assign sfrdatao = r_sfrdatao;
   assign sfrwe    = r_sfrwe;
   assign rmwinstr = r_rmw;
   assign busy     = r_busy;
   assign done     = r_done;
   assign rdata    = r_rdata;
   assign bitval   = r_bitval;
   assign err      = r_err;

endmodule

// File: tb/tb_sfr_access_ctrl.sv
// Bench for sfr_access_ctrl: port/SFR responder model plus a transaction-level
// reference of the expected bus writes, read data and completion timing.
module tb_sfr_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [2:0] op;
   logic [6:0] addr;
   logic [2:0] bitsel;
   logic [7:0] wdata;
   logic [7:0] sfrdatai;
   logic [6:0] sfraddr;
   logic [7:0] sfrdatao;
   logic       sfrwe;
   logic       rmwinstr;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       bitval;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sfr_access_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .bitsel(bitsel),
      .wdata(wdata), .sfrdatai(sfrdatai), .sfraddr(sfraddr), .sfrdatao(sfrdatao),
      .sfrwe(sfrwe), .rmwinstr(rmwinstr), .busy(busy), .done(done),
      .rdata(rdata), .bitval(bitval), .err(err)
   );

   // Responder: ports P0..P3 at 0x00/0x10/0x20/0x30 return pins unless RMW
   function automatic logic is_port(input logic [6:0] a);
      return (a == 7'h00) || (a == 7'h10) || (a == 7'h20) || (a == 7'h30);
   endfunction

   function automatic logic [7:0] pins_of(input logic [6:0] a);
      case (a)
         7'h00:   return 8'h3C;
         7'h10:   return 8'h0F;
         7'h20:   return 8'hC3;
         7'h30:   return 8'h99;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] init_latch(input int unsigned a);
      return (a == 16) ? 8'hFF : 8'(a ^ 32'h5A);
   endfunction

   logic [7:0] slv_latch [0:127];
   logic       ld_all;

   always @(posedge clk) begin
      if (ld_all) begin
         for (int i = 0; i < 128; i++) slv_latch[i] <= init_latch(i);
      end else if (sfrwe) begin
         slv_latch[sfraddr] <= sfrdatao;
      end
   end

   assign sfrdatai = (is_port(sfraddr) && !rmwinstr) ? pins_of(sfraddr) : slv_latch[sfraddr];

   // Reference model state
   logic [7:0] exp_mem [0:127];
   logic [7:0] exp_rdata;
   logic       exp_bitval;
   logic       exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_op(input logic [2:0] o, input logic [6:0] a, input logic [2:0] b,
                           input logic [7:0] wd, output int lat, output bit we,
                           output logic [7:0] wv);
      int unsigned old, w, bit_on;
      we = 1'b0;
      wv = 8'h00;
      if (o >= 3'd2 && o <= 3'd4 && (a % 8) != 0) begin
         exp_err    = 1'b1;
         exp_bitval = 1'b0;
         lat        = 1;
      end else if (o == 3'd1) begin
         exp_err    = 1'b0;
         exp_bitval = 1'b0;
         we         = 1'b1;
         wv         = wd;
         lat        = 2;
      end else begin
         exp_err    = 1'b0;
         exp_bitval = 1'b0;
         old        = (o == 3'd0 && is_port(a)) ? pins_of(a) : exp_mem[a];
         exp_rdata  = 8'(old);
         w          = 1 << b;
         bit_on     = (old / w) % 2;
         lat        = (o == 3'd0) ? 2 : 3;
         we         = (o != 3'd0);
         case (o)
            3'd2: wv = 8'(bit_on ? old : old + w);
            3'd3: wv = 8'(bit_on ? old - w : old);
            3'd4: wv = 8'(bit_on ? old - w : old + w);
            3'd5: wv = 8'(old) & wd;
            3'd6: wv = 8'(old) | wd;
            3'd7: wv = 8'(old) ^ wd;
            default: wv = 8'h00;
         endcase
         if (o >= 3'd2 && o <= 3'd4) exp_bitval = bit_on[0];
      end
      if (we) exp_mem[a] = wv;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [6:0] a, input logic [2:0] b,
                         input logic [7:0] wd);
      int         lat, cyc, n_we, n_rmw;
      bit         we, got_done;
      logic [7:0] wv, seen_d;
      logic [6:0] seen_a;
      @(negedge clk);
      check("idle_busy",    32'(busy),    32'(0));
      check("idle_sfraddr", 32'(sfraddr), 32'(0));
      check("idle_sfrwe",   32'(sfrwe),   32'(0));
      model_op(o, a, b, wd, lat, we, wv);
      req = 1'b1; op = o; addr = a; bitsel = b; wdata = wd;
      @(posedge clk);
      #1;
      req = 1'b0; op = 3'($urandom); addr = 7'($urandom);
      bitsel = 3'($urandom); wdata = 8'($urandom);
      cyc = 0; n_we = 0; n_rmw = 0; got_done = 1'b0; seen_a = '0; seen_d = '0;
      while (!got_done && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy_after_accept", 32'(busy), 32'(1));
         if (sfrwe) begin
            n_we++;
            seen_a = sfraddr;
            seen_d = sfrdatao;
         end
         if (rmwinstr) n_rmw++;
         if (done) got_done = 1'b1;
      end
      check("latency", got_done ? 32'(cyc) : 32'(99), 32'(lat));
      check("sfrwe_pulses", 32'(n_we), 32'(we));
      if (we) begin
         check("wr_addr", 32'(seen_a), 32'(a));
         check("wr_data", 32'(seen_d), 32'(wv));
      end
      check("rmw_cycles", 32'(n_rmw), (o >= 3'd2 && !exp_err) ? 32'(2) : 32'(0));
      check("rdata",  32'(rdata),  32'(exp_rdata));
      check("bitval", 32'(bitval), 32'(exp_bitval));
      check("err",    32'(err),    32'(exp_err));
      check("latch",  32'(slv_latch[a]), 32'(exp_mem[a]));
   endtask

   logic [6:0] addr_tab [0:5];
   bit         exp_we   [0:79];
   bit         exp_done [0:79];
   logic [7:0] exp_wv   [0:79];
   logic [6:0] exp_wa   [0:79];

   initial begin
      int         lat, nxt;
      bit         we;
      logic [7:0] wv;
      logic [2:0] ro, rb;
      logic [6:0] ra;
      logic [7:0] rw;

      addr_tab[0] = 7'h00; addr_tab[1] = 7'h10; addr_tab[2] = 7'h11;
      addr_tab[3] = 7'h20; addr_tab[4] = 7'h48; addr_tab[5] = 7'h7F;
      for (int i = 0; i < 128; i++) exp_mem[i] = init_latch(i);
      for (int i = 0; i < 80; i++) begin
         exp_we[i] = 1'b0; exp_done[i] = 1'b0; exp_wv[i] = '0; exp_wa[i] = '0;
      end
      exp_rdata = 8'h00; exp_bitval = 1'b0; exp_err = 1'b0;

      rst = 1'b0; ld_all = 1'b1; req = 1'b0; op = '0; addr = '0; bitsel = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_sfraddr",  32'(sfraddr),  32'(0));
      check("rst_sfrdatao", 32'(sfrdatao), 32'(0));
      check("rst_sfrwe",    32'(sfrwe),    32'(0));
      check("rst_rmw",      32'(rmwinstr), 32'(0));
      check("rst_busy",     32'(busy),     32'(0));
      check("rst_done",     32'(done),     32'(0));
      check("rst_rdata",    32'(rdata),    32'(0));
      check("rst_bitval",   32'(bitval),   32'(0));
      check("rst_err",      32'(err),      32'(0));
      ld_all = 1'b0;
      rst    = 1'b1;

      run_op(3'd1, 7'h00, 3'd0, 8'hA5);
      run_op(3'd0, 7'h10, 3'd0, 8'h00);
      run_op(3'd4, 7'h10, 3'd7, 8'h00);
      run_op(3'd1, 7'h10, 3'd0, 8'hF0);
      run_op(3'd5, 7'h10, 3'd0, 8'h3C);
      run_op(3'd1, 7'h10, 3'd0, 8'hF0);
      run_op(3'd6, 7'h10, 3'd0, 8'h3C);
      run_op(3'd1, 7'h10, 3'd0, 8'hF0);
      run_op(3'd7, 7'h10, 3'd0, 8'h3C);
      run_op(3'd2, 7'h11, 3'd0, 8'h00);
      run_op(3'd3, 7'h20, 3'd6, 8'h00);
      run_op(3'd2, 7'h30, 3'd2, 8'h00);
      run_op(3'd0, 7'h11, 3'd0, 8'h00);
      run_op(3'd0, 7'h30, 3'd0, 8'h00);

      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom), addr_tab[$urandom_range(0, 5)], 3'($urandom), 8'($urandom));
      end

      // req held high; only the cycle the model predicts as IDLE carries the real op
      nxt = 0;
      req = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         check("held_sfrwe", 32'(sfrwe), 32'(exp_we[k]));
         check("held_done",  32'(done),  32'(exp_done[k]));
         if (exp_we[k]) begin
            check("held_wr_addr", 32'(sfraddr),  32'(exp_wa[k]));
            check("held_wr_data", 32'(sfrdatao), 32'(exp_wv[k]));
         end
         if (exp_done[k]) begin
            check("held_rdata", 32'(rdata), 32'(exp_rdata));
            check("held_err",   32'(err),   32'(exp_err));
         end
         if (k == nxt) begin
            if (k >= 60) begin
               req = 1'b0;
               break;
            end
            ro = 3'($urandom); ra = addr_tab[$urandom_range(0, 5)];
            rb = 3'($urandom); rw = 8'($urandom);
            model_op(ro, ra, rb, rw, lat, we, wv);
            op = ro; addr = ra; bitsel = rb; wdata = rw;
            exp_done[k + lat] = 1'b1;
            if (we) begin
               exp_we[k + lat - 1] = 1'b1;
               exp_wa[k + lat - 1] = ra;
               exp_wv[k + lat - 1] = wv;
            end
            nxt = k + lat + 1;
         end else begin
            op = 3'($urandom); addr = 7'($urandom); bitsel = 3'($urandom); wdata = 8'($urandom);
         end
      end
      req = 1'b0;

      // Reset during the RD cycle of a SETB: aborted, no write, no done
      @(negedge clk);
      check("pre_abort_busy", 32'(busy), 32'(0));
      req = 1'b1; op = 3'd2; addr = 7'h10; bitsel = 3'd3; wdata = 8'h00;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("abort_in_rd", 32'(rmwinstr), 32'(1));
      rst = 1'b0;
      @(negedge clk);
      check("abort_sfraddr",  32'(sfraddr),  32'(0));
      check("abort_sfrdatao", 32'(sfrdatao), 32'(0));
      check("abort_sfrwe",    32'(sfrwe),    32'(0));
      check("abort_rmw",      32'(rmwinstr), 32'(0));
      check("abort_busy",     32'(busy),     32'(0));
      check("abort_done",     32'(done),     32'(0));
      check("abort_rdata",    32'(rdata),    32'(0));
      check("abort_bitval",   32'(bitval),   32'(0));
      check("abort_err",      32'(err),      32'(0));
      rst = 1'b1;
      exp_rdata = 8'h00; exp_bitval = 1'b0; exp_err = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_abort_quiet", 32'({sfrwe, done, busy}), 32'(0));
      end
      run_op(3'd1, 7'h20, 3'd0, 8'h5E);

      for (int i = 0; i < 128; i++) begin
         check("final_latch", 32'(slv_latch[i]), 32'(exp_mem[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sfr_access_ctrl.md
Name: sfr_access_ctrl

Overview:
- CPU-side initiator of the internal SFR bus; the ports unit and the other SFR peripherals are the responders.
- Sequences single-byte and bit accesses from the execution unit into SFR bus cycles: plain read, plain write, and read-modify-write (RMW).
- For RMW ops it drives rmwinstr so that port SFRs return their output latch instead of the pin value.
- Sits between the instruction execution unit and the SFR address/data/write-enable bus.

Parameters:
- ADDR_W, 7, SFR direct address width (direct address minus bit 7).
- DATA_W, 8, SFR data width.

Ports:
- clk  in  1  global clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on rising clk edge)
- req  in  1  access request from CPU, sampled only in IDLE
- op  in  3  0=READ 1=WRITE 2=SETB 3=CLRB 4=CPLB 5=ANL 6=ORL 7=XRL
- addr  in  ADDR_W  target SFR address
- bitsel  in  3  bit index for SETB/CLRB/CPLB
- wdata  in  DATA_W  write data / ANL-ORL-XRL operand
- sfrdatai  in  DATA_W  read data returned by the SFR read mux
- sfraddr  out  ADDR_W  SFR bus address (registered)
- sfrdatao  out  DATA_W  SFR bus write data (registered)
- sfrwe  out  1  SFR write enable (registered, one-cycle pulse)
- rmwinstr  out  1  RMW indicator to responders (registered)
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  byte read in RD phase, valid from done onward
- bitval  out  1  pre-modify value of rdata[bitsel] (bit ops only; 0 otherwise)
- err  out  1  bit op to non-bit-addressable SFR; valid with done

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; sfraddr, sfrdatao, rdata = 0; sfrwe, rmwinstr, busy, done, bitval, err = 0.
- FSM states: IDLE, RD, WR, DONE. All outputs registered.
- IDLE
  - req=1 latches op, addr, bitsel, wdata and clears err and bitval.
  - WRITE -> WR; any other op -> RD.
  - Exception: op 2-4 with addr[2:0] != 0 -> DONE with err=1, no bus cycle, sfrwe never asserted.
- RD
  - sfraddr=addr; rmwinstr=1 for ops 2-7, 0 for READ.
  - sfrdatai captured into rdata at the end of the RD cycle.
  - READ -> DONE; ops 2-7 -> WR.
- WR
  - sfraddr=addr; sfrwe=1 for exactly this cycle; rmwinstr stays as in RD (0 for WRITE).
  - sfrdatao by op: WRITE: wdata. SETB: rdata|(1<<bitsel). CLRB: rdata&~(1<<bitsel). CPLB: rdata^(1<<bitsel). ANL: rdata&wdata. ORL: rdata|wdata. XRL: rdata^wdata.
  - Next state: DONE.
- DONE
  - done=1 for one cycle; sfraddr=0, sfrwe=0, rmwinstr=0; then IDLE.
  - busy=0 in the IDLE cycle after DONE.
- Latency from the req-accept edge to the done cycle: WRITE 2, READ 2, RMW 3, err 1. Back-to-back: the next req is accepted in the cycle after done.
- req while busy=1 is ignored, not queued; the requester holds req until done.
- bitval = rdata[bitsel] captured in RD for ops 2-4.
- In IDLE: sfraddr=0, sfrdatao holds its last value, sfrwe=0.
- Reset mid-operation: the state returns to IDLE. A write whose sfrwe was already high during the reset edge completes at that edge; no further bus activity follows and no done is issued.
- Bit addressability: an SFR is bit-addressable iff addr[2:0]==0.

Test Plan:
- Reset with rst=0 for 2 cycles -> all outputs 0, busy=0; then WRITE addr=0x00 wdata=0xA5 -> sfrwe high 1 cycle with sfraddr=0x00, sfrdatao=0xA5; done 2 cycles after accept; P0 model latch=0xA5.
- Slave model P1 at 0x10 with latch=0xFF, pins=0x0F; READ -> rmwinstr=0, rdata=0x0F; then CPLB bitsel=7 -> rmwinstr=1 in RD/WR, rdata=0xFF, bitval=1, sfrdatao=0x7F, latch=0x7F.
- ANL addr=0x10 with latch 0xF0, wdata=0x3C -> sfrdatao=0x30; ORL -> 0xFC; XRL -> 0xCC; each done 3 cycles after accept.
- SETB addr=0x11 bitsel=0 -> err=1 with done 1 cycle after accept; sfrwe and rmwinstr stay 0; slave unchanged.
- req held high continuously with alternating ops -> each op accepted only in IDLE, no dropped or duplicated sfrwe; requests while busy=1 cause no bus activity.
- rst=0 during the RD cycle of a SETB -> no sfrwe, no done, state IDLE, outputs at reset values; the next WRITE completes normally.
